// File: rtl/fxy_sweep.sv
// fxy_sweep: presents every input row of an N-input reducing NOR/NAND/XOR/XNOR
// together with its function value and a running count of true rows.
// Ports: clk, reset (sync, active-high), start (sweep request, IDLE only),
// op (00 NOR, 01 NAND, 10 XOR, 11 XNOR), busy (RUN), valid (one per row),
// x (row), s (f(op,x)), ones (true rows so far), done (pulse after last row).
// Optional FXY_SWEEP_MINTERM_LOG_EN adds mask: bit i holds s of row i.
module fxy_sweep #(
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             valid,
    output logic [N-1:0]     x,
    output logic             s,
    output logic [N:0]       ones,
`ifdef FXY_SWEEP_MINTERM_LOG_EN
    output logic             done,
    output logic [(1<<N)-1:0] mask
`else
    output logic             done
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state_q, state_d;
    logic [N:0]   cnt_q, cnt_d, ones_q, ones_d;
    logic [N-1:0] x_q, x_d, row;
    logic [1:0]   op_q, op_d;
    logic         s_q, s_d, valid_q, valid_d, fv;
`ifdef FXY_SWEEP_MINTERM_LOG_EN
    logic [(1<<N)-1:0] mask_q, mask_d;
    assign mask = mask_q;
`endif
    assign row = cnt_q[N-1:0];
    assign fv  = op_q[1] ? (op_q[0] ? ~^row : ^row) : (op_q[0] ? ~&row : ~|row);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ones_q  <= '0;
            x_q     <= '0;
            op_q    <= '0;
            s_q     <= 1'b0;
            valid_q <= 1'b0;
`ifdef FXY_SWEEP_MINTERM_LOG_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            x_q     <= x_d;
            op_q    <= op_d;
            s_q     <= s_d;
            valid_q <= valid_d;
`ifdef FXY_SWEEP_MINTERM_LOG_EN
            mask_q  <= mask_d;
`endif
        end
    end
    // cnt_q[N] rises once every row has been presented, so x never wraps.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        x_d     = x_q;
        op_d    = op_q;
        s_d     = s_q;
        valid_d = 1'b0;
`ifdef FXY_SWEEP_MINTERM_LOG_EN
        mask_d  = mask_q;
`endif
        if (state_q == IDLE && start) begin
            state_d = RUN;
            op_d    = op;
            cnt_d   = '0;
            ones_d  = '0;
`ifdef FXY_SWEEP_MINTERM_LOG_EN
            mask_d  = '0;
`endif
        end else if (state_q == RUN && cnt_q[N]) begin
            state_d = DONE;
        end else if (state_q == RUN) begin
            valid_d = 1'b1;
            x_d     = row;
            s_d     = fv;
            ones_d  = ones_q + (N+1)'(fv);
            cnt_d   = cnt_q + (N+1)'(1);
`ifdef FXY_SWEEP_MINTERM_LOG_EN
            mask_d[row] = fv;
`endif
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    assign busy  = state_q == RUN;
    assign done  = state_q == DONE;
    assign valid = valid_q;
    assign x     = x_q;
    assign s     = s_q;
    assign ones  = ones_q;
endmodule

// File: tb/tb_fxy_sweep.sv
// tb_fxy_sweep: checks an N=2 and an N=3 fxy_sweep against a timeline model.
module tb_fxy_sweep;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [1:0] op = 2'b00;
    logic busy0, valid0, s0, done0, busy1, valid1, s1, done1;
    logic [1:0] x0;
    logic [2:0] x1, ones0;
    logic [3:0] ones1;
`ifdef FXY_SWEEP_MINTERM_LOG_EN
    logic [3:0] mask0;
    logic [7:0] mask1;
`endif
    always #5 clk = ~clk;

    fxy_sweep #(.N(2)) u0 (.clk(clk), .reset(reset), .start(start), .op(op), .busy(busy0),
        .valid(valid0), .x(x0), .s(s0), .ones(ones0),
`ifdef FXY_SWEEP_MINTERM_LOG_EN
        .mask(mask0),
`endif
        .done(done0));
    fxy_sweep #(.N(3)) u1 (.clk(clk), .reset(reset), .start(start), .op(op), .busy(busy1),
        .valid(valid1), .x(x1), .s(s1), .ones(ones1),
`ifdef FXY_SWEEP_MINTERM_LOG_EN
        .mask(mask1),
`endif
        .done(done1));

    int n_chk = 0, n_fail = 0, cyc = 0, st = 0, donecyc0 = 0;
    bit armed = 0;
    int nn[2] = '{2, 3};
    int t[2] = '{-1, -1};
    int mx[2], mones[2], dn[2], lastones[2];
    logic [1:0] mop[2];
    logic ms[2];
    logic [7:0] mmask[2], rec[2];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Function value straight from its definition over the n-bit row index.
    function automatic logic fm(input logic [1:0] o, input int r, input int n);
        int pc = 0;
        for (int b = 0; b < n; b++) pc += (r >> b) & 1;
        case (o)
            2'b00: return pc == 0;
            2'b01: return pc != n;
            2'b10: return pc % 2 == 1;
            default: return pc % 2 == 0;
        endcase
    endfunction

    // t = cycles since the accepted start edge: 0 setup, 1..2^n rows, 2^n+1 done.
    always @(posedge clk) begin
        logic [31:0] ab[2], av[2], ax[2], as[2], ao[2], ad[2];
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int r;
            r = 1 << nn[i];
            if (reset) begin
                t[i] = -1; mop[i] = 0; mx[i] = 0; ms[i] = 0; mones[i] = 0; mmask[i] = 0;
            end else if (t[i] < 0) begin
                if (start) begin t[i] = 0; mop[i] = op; mones[i] = 0; mmask[i] = 0; end
            end else if (t[i] == r + 1) begin
                t[i] = -1;
            end else begin
                t[i]++;
                if (t[i] <= r) begin
                    mx[i] = t[i] - 1;
                    ms[i] = fm(mop[i], mx[i], nn[i]);
                    mones[i] = 0;
                    for (int q = 0; q <= mx[i]; q++) mones[i] += int'(fm(mop[i], q, nn[i]));
                    mmask[i][mx[i]] = ms[i];
                end
            end
        end
        if (reset) armed = 1;
        #1;
        ab = '{32'(busy0), 32'(busy1)}; av = '{32'(valid0), 32'(valid1)};
        ax = '{32'(x0), 32'(x1)}; as = '{32'(s0), 32'(s1)};
        ao = '{32'(ones0), 32'(ones1)}; ad = '{32'(done0), 32'(done1)};
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                int r;
                r = 1 << nn[i];
                chk($sformatf("busy%0d", i), ab[i], 32'(t[i] >= 0 && t[i] <= r));
                chk($sformatf("valid%0d", i), av[i], 32'(t[i] >= 1 && t[i] <= r));
                chk($sformatf("done%0d", i), ad[i], 32'(t[i] == r + 1));
                chk($sformatf("x%0d", i), ax[i], 32'(mx[i]));
                chk($sformatf("s%0d", i), as[i], 32'(ms[i]));
                chk($sformatf("ones%0d", i), ao[i], 32'(mones[i]));
                if (av[i] == 1) rec[i][ax[i][2:0]] = as[i][0];
                dn[i] += int'(ad[i]);
                lastones[i] = int'(ao[i]);
            end
`ifdef FXY_SWEEP_MINTERM_LOG_EN
            chk("mask0", 32'(mask0), 32'(mmask[0][3:0]));
            chk("mask1", 32'(mask1), 32'(mmask[1]));
`endif
            if (done0) donecyc0 = cyc;
        end
    end

    task automatic sweep(input logic [1:0] o, input int wait_cycles);
        rec = '{8'h00, 8'h00}; dn = '{0, 0};
        op = o; start = 1'b1; st = cyc + 1;
        @(negedge clk) start = 1'b0;
        repeat (wait_cycles) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_ones", 32'(ones1), 0);
        repeat (2) @(negedge clk);
        sweep(2'b00, 12);
        chk("nor_rows", 32'(rec[0]), 32'h01);
        chk("nor_ones", 32'(lastones[0]), 1);
        chk("nor_done", 32'(dn[0]), 1);
        sweep(2'b01, 12);
        chk("nand_rows", 32'(rec[0]), 32'h07);
        chk("nand_ones", 32'(lastones[0]), 3);
        chk("nand_latency", 32'(donecyc0 - st), 5);
        sweep(2'b10, 12);
        chk("xor3_rows", 32'(rec[1]), 32'h96);
        chk("xor3_ones", 32'(lastones[1]), 4);
        chk("xor2_rows", 32'(rec[0]), 32'h06);
        sweep(2'b00, 2);
        start = 1'b1; op = 2'b11;
        @(negedge clk) start = 1'b0;
        repeat (12) @(negedge clk);
        chk("restart_rows", 32'(rec[0]), 32'h01);
        chk("restart_done", 32'(dn[0]), 1);
        chk("restart_ones", 32'(lastones[0]), 1);
        sweep(2'b01, 3);
        chk("mid_x", 32'(x0), 2);
        reset = 1'b1; start = 1'b1;
        @(negedge clk) begin reset = 1'b0; start = 1'b0; end
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_valid", 32'(valid0), 0);
        chk("midrst_x", 32'(x0), 0);
        chk("midrst_ones", 32'(ones0), 0);
        dn = '{0, 0};
        repeat (10) @(negedge clk);
        chk("midrst_nodone", 32'(dn[0]), 0);
        op = 2'b01; start = 1'b1;
        repeat (12) @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_dones0", 32'(dn[0]), 2);
        chk("held_dones1", 32'(dn[1]), 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fxy_sweep.md
FXY_SWEEP -- requirements
Module: fxy_sweep

Interface
REQ-001 Parameter: N, default 2, number of function inputs; legal range 1..8.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a truth-table sweep; sampled only in IDLE.
REQ-005 Port: op  input  2  function select: 00 NOR, 01 NAND, 10 XOR, 11 XNOR, all reducing across N bits.
REQ-006 Port: busy  output  1  high in RUN state.
REQ-007 Port: valid  output  1  high for exactly one cycle per presented row.
REQ-008 Port: x  output  N  current input vector (row index).
REQ-009 Port: s  output  1  function value for x under latched op.
REQ-010 Port: ones  output  N+1  running count of rows with s=1.
REQ-011 Port: done  output  1  one-cycle pulse after last row.

Function
REQ-012 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-013 IDLE: start=1 at edge k -> latch op, clear row counter and ones, enter RUN.
REQ-014 op latched at start; op changes during RUN/DONE have no effect.
REQ-015 RUN: edge k+1 presents x=0, valid=1; each following edge increments x by 1.
REQ-016 Row x=2^N-1 presented at edge k+2^N; next edge enters DONE with done=1, valid=0, busy=0.
REQ-017 DONE lasts exactly one cycle, then IDLE unconditionally; start during DONE ignored.
REQ-018 s registered with x on same edge: s = f(op, x), no extra latency.
REQ-019 ones registered on same edge: equals count of s=1 among rows 0..current x inclusive.
REQ-020 ones, x, s hold last values in DONE and IDLE until next accepted start.
REQ-021 start during RUN ignored; sweep not restarted or extended.
REQ-022 Row counter N+1 bits wide internally; x never wraps during a sweep; no row repeated or skipped.
REQ-023 start held high continuously: new sweep accepted on first IDLE cycle after DONE.

Reset
REQ-024 reset=1 at any edge, including mid-RUN or DONE -> IDLE next cycle.
REQ-025 Reset values: busy=0, valid=0, done=0, x=0, s=0, ones=0, latched op=00.
REQ-026 reset has priority over start at the same edge.

Configuration
REQ-027 Macro FXY_SWEEP_MINTERM_LOG_EN defined: extra output port mask, width 2^N, bit i = s of row i.
REQ-028 With macro: mask cleared on accepted start, bit written on each valid row, held after DONE, cleared by reset.
REQ-029 Without macro: no mask port, no mask storage; all other behaviour identical.

Verification
REQ-030 N=2, op=00, start pulse -> rows x=0..3 with s=1,0,0,0; done pulse; ones=1; mask=0001.
REQ-031 N=2, op=01 -> s=1,1,1,0; ones=3; mask=0111; done exactly 5 cycles after start edge.
REQ-032 N=3, op=10 -> s=0,1,1,0,1,0,0,1; ones=4; mask=10010110.
REQ-033 N=2, start re-pulsed and op toggled at row 1 -> sweep unaffected, single done, ones per original op.
REQ-034 N=2, reset asserted at row 2 -> next cycle busy=0, valid=0, x=0, ones=0, no done pulse.
REQ-035 N=2, start held high across two sweeps -> DONE, then immediate restart; ones cleared to 0 before row 0 count.
